// File: rtl/xaui_phy_ctrl_pkg.sv
// Shared constants for the XAUI transceiver control OPB slave:
// register map, field widths and the bus FSM encoding.
package xaui_phy_ctrl_pkg;

    localparam logic [2:0] REG_RXEQMIX   = 3'd0;
    localparam logic [2:0] REG_RXEQPOLE  = 3'd1;
    localparam logic [2:0] REG_TXPREEMPH = 3'd2;
    localparam logic [2:0] REG_TXDIFF    = 3'd3;
    localparam logic [2:0] REG_STATUS    = 3'd4;
    localparam logic [2:0] REG_STICKY    = 3'd5;
    localparam logic [2:0] REG_LINKDN    = 3'd6;

    localparam int unsigned W_RXEQMIX  = 2;
    localparam int unsigned W_RXEQPOLE = 4;
    localparam int unsigned W_TXPRE    = 3;
    localparam int unsigned W_TXDIFF   = 3;
    localparam int unsigned W_STATUS   = 8;
    localparam int unsigned W_LINKDN   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_e;

    // Channel-select field width; never narrower than one bit.
    function automatic int unsigned ch_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xaui_phy_ctrl_opb_if.sv
// OPB slave-side bus signals. Data, byte-enable and address keep the
// big-endian OPB numbering, so index 31 of a data word is its LSB.
interface xaui_phy_ctrl_opb_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/xaui_ch_status.sv
// Per-channel status path: two-flop synchroniser, sticky bits with
// write-1-to-clear, and a saturating counter of link-down events.
module xaui_ch_status
    import xaui_phy_ctrl_pkg::*;
#(
    parameter int unsigned LINK_BIT = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W_STATUS-1:0] status_async,
    input  logic [W_STATUS-1:0] sticky_clr,
    input  logic                cnt_clr,
    output logic [W_STATUS-1:0] status_sync,
    output logic [W_STATUS-1:0] sticky,
    output logic [W_LINKDN-1:0] linkdn_cnt
);

    logic [W_STATUS-1:0] sync1_q, sync2_q;
    logic [W_STATUS-1:0] sticky_q, sticky_d;
    logic [W_LINKDN-1:0] cnt_q, cnt_d;
    logic                link_prev_q;
    logic                link_fall;

    // A set and a clear in the same cycle leave the bit set; likewise a
    // link-down event coincident with a clear leaves a count of one.
    always_comb begin
        link_fall = link_prev_q & ~sync2_q[LINK_BIT];
        sticky_d  = (sticky_q & ~sticky_clr) | sync2_q;
        cnt_d     = cnt_q;
        if (cnt_clr) begin
            cnt_d = link_fall ? W_LINKDN'(1) : '0;
        end else if (link_fall && (cnt_q != '1)) begin
            cnt_d = cnt_q + W_LINKDN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
            link_prev_q <= 1'b0;
        end else begin
            sync1_q     <= status_async;
            sync2_q     <= sync1_q;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            link_prev_q <= sync2_q[LINK_BIT];
        end
    end

    assign status_sync = sync2_q;
    assign sticky      = sticky_q;
    assign linkdn_cnt  = cnt_q;

endmodule

// File: rtl/xaui_phy_ctrl_opb.sv
// OPB slave holding transceiver tuning and status registers for
// C_NUM_CH XAUI channels, 32 bytes of register space per channel.
module xaui_phy_ctrl_opb
    import xaui_phy_ctrl_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int unsigned C_NUM_CH     = 4,
    parameter logic [2:0]  C_TXDIFF_RST = 3'b100,
    parameter int unsigned C_LINK_BIT   = 7
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    xaui_phy_ctrl_opb_if.slave      opb,
    output logic [2*C_NUM_CH-1:0]   rxeqmix,
    output logic [4*C_NUM_CH-1:0]   rxeqpole,
    output logic [3*C_NUM_CH-1:0]   txpreemphasis,
    output logic [3*C_NUM_CH-1:0]   txdiffctrl,
    input  logic [8*C_NUM_CH-1:0]   xaui_status
);

    localparam int unsigned CH_BITS = ch_bits(C_NUM_CH);

    bus_state_e  state_q, state_d;
    logic [31:0] dbus_q, dbus_d;
    logic [31:0] a_trans, wdata, rdata;
    logic        a_match, be_lsb;
    logic [CH_BITS-1:0] ch;
    logic [2:0]  reg_idx;

    logic [C_NUM_CH-1:0][W_RXEQMIX-1:0]  rxeqmix_q, rxeqmix_d;
    logic [C_NUM_CH-1:0][W_RXEQPOLE-1:0] rxeqpole_q, rxeqpole_d;
    logic [C_NUM_CH-1:0][W_TXPRE-1:0]    txpre_q, txpre_d;
    logic [C_NUM_CH-1:0][W_TXDIFF-1:0]   txdiff_q, txdiff_d;
    logic [C_NUM_CH-1:0][W_STATUS-1:0]   status_s, sticky_s, sticky_clr;
    logic [C_NUM_CH-1:0][W_LINKDN-1:0]   cnt_s;
    logic [C_NUM_CH-1:0]                 cnt_clr;

    always_comb begin
        a_trans = opb.OPB_ABus - C_BASEADDR;
        a_match = (opb.OPB_ABus >= C_BASEADDR) && (opb.OPB_ABus <= C_HIGHADDR);
        ch      = a_trans[5 +: CH_BITS];
        reg_idx = a_trans[4:2];
        wdata   = opb.OPB_DBus;
        be_lsb  = opb.OPB_BE[3];
    end

    // Channel match by loop so an out-of-range index selects nothing.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < C_NUM_CH; i++) begin
            if (ch == CH_BITS'(i)) begin
                case (reg_idx)
                    REG_RXEQMIX:   rdata = 32'(rxeqmix_q[i]);
                    REG_RXEQPOLE:  rdata = 32'(rxeqpole_q[i]);
                    REG_TXPREEMPH: rdata = 32'(txpre_q[i]);
                    REG_TXDIFF:    rdata = 32'(txdiff_q[i]);
                    REG_STATUS:    rdata = 32'(status_s[i]);
                    REG_STICKY:    rdata = 32'(sticky_s[i]);
                    REG_LINKDN:    rdata = 32'(cnt_s[i]);
                    default:       rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dbus_d     = '0;
        rxeqmix_d  = rxeqmix_q;
        rxeqpole_d = rxeqpole_q;
        txpre_d    = txpre_q;
        txdiff_d   = txdiff_q;
        sticky_clr = '0;
        cnt_clr    = '0;
        case (state_q)
            IDLE: begin
                if (a_match && opb.OPB_select) begin
                    state_d = ACK;
                    dbus_d  = rdata;
                    if (!opb.OPB_RNW) begin
                        for (int unsigned i = 0; i < C_NUM_CH; i++) begin
                            if (ch == CH_BITS'(i)) begin
                                case (reg_idx)
                                    REG_RXEQMIX:   if (be_lsb) rxeqmix_d[i]  = wdata[W_RXEQMIX-1:0];
                                    REG_RXEQPOLE:  if (be_lsb) rxeqpole_d[i] = wdata[W_RXEQPOLE-1:0];
                                    REG_TXPREEMPH: if (be_lsb) txpre_d[i]    = wdata[W_TXPRE-1:0];
                                    REG_TXDIFF:    if (be_lsb) txdiff_d[i]   = wdata[W_TXDIFF-1:0];
                                    REG_STICKY:    if (be_lsb) sticky_clr[i] = wdata[W_STATUS-1:0];
                                    REG_LINKDN:    cnt_clr[i] = 1'b1;
                                    default:       ;
                                endcase
                            end
                        end
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q    <= IDLE;
            dbus_q     <= '0;
            rxeqmix_q  <= '0;
            rxeqpole_q <= '0;
            txpre_q    <= '0;
            txdiff_q   <= {C_NUM_CH{C_TXDIFF_RST}};
        end else begin
            state_q    <= state_d;
            dbus_q     <= dbus_d;
            rxeqmix_q  <= rxeqmix_d;
            rxeqpole_q <= rxeqpole_d;
            txpre_q    <= txpre_d;
            txdiff_q   <= txdiff_d;
        end
    end

    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
        xaui_ch_status #(
            .LINK_BIT(C_LINK_BIT)
        ) u_ch (
            .clk         (OPB_Clk),
            .rst_n       (OPB_Rst_n),
            .status_async(xaui_status[8*g +: 8]),
            .sticky_clr  (sticky_clr[g]),
            .cnt_clr     (cnt_clr[g]),
            .status_sync (status_s[g]),
            .sticky      (sticky_s[g]),
            .linkdn_cnt  (cnt_s[g])
        );
    end

    assign opb.Sl_DBus    = dbus_q;
    assign opb.Sl_xferAck = (state_q == ACK);
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    assign rxeqmix       = rxeqmix_q;
    assign rxeqpole      = rxeqpole_q;
    assign txpreemphasis = txpre_q;
    assign txdiffctrl    = txdiff_q;

    logic unused_ok;
    assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], a_trans[31:5+CH_BITS],
                         a_trans[1:0], wdata[31:W_STATUS]};

endmodule

// File: tb/tb_xaui_phy_ctrl_opb.sv
// Directed bench: a 4-channel instance for the main register behaviour and a
// 3-channel instance with a 4-channel window for out-of-range accesses.
module tb_xaui_phy_ctrl_opb;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] abus = '0;
    logic [31:0] dbus = '0;
    logic [0:3]  be = '0;
    logic        rnw = 1'b1;
    logic        sel = 1'b0;
    logic        use3 = 1'b0;

    xaui_phy_ctrl_opb_if bus4 ();
    xaui_phy_ctrl_opb_if bus3 ();

    assign bus4.OPB_ABus    = abus;
    assign bus4.OPB_DBus    = dbus;
    assign bus4.OPB_BE      = be;
    assign bus4.OPB_RNW     = rnw;
    assign bus4.OPB_select  = sel & ~use3;
    assign bus4.OPB_seqAddr = 1'b0;
    assign bus3.OPB_ABus    = abus;
    assign bus3.OPB_DBus    = dbus;
    assign bus3.OPB_BE      = be;
    assign bus3.OPB_RNW     = rnw;
    assign bus3.OPB_select  = sel & use3;
    assign bus3.OPB_seqAddr = 1'b0;

    logic [7:0]  mix4;
    logic [15:0] pole4;
    logic [11:0] pre4, diff4;
    logic [31:0] st4 = '0;
    logic [5:0]  mix3;
    logic [11:0] pole3;
    logic [8:0]  pre3, diff3;
    logic [23:0] st3 = '0;

    xaui_phy_ctrl_opb #(
        .C_BASEADDR(BASE), .C_HIGHADDR(BASE + 32'h7F), .C_NUM_CH(4),
        .C_TXDIFF_RST(3'b100), .C_LINK_BIT(7)
    ) dut4 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus4),
        .rxeqmix(mix4), .rxeqpole(pole4), .txpreemphasis(pre4),
        .txdiffctrl(diff4), .xaui_status(st4)
    );

    xaui_phy_ctrl_opb #(
        .C_BASEADDR(BASE), .C_HIGHADDR(BASE + 32'h7F), .C_NUM_CH(3),
        .C_TXDIFF_RST(3'b100), .C_LINK_BIT(7)
    ) dut3 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .opb(bus3),
        .rxeqmix(mix3), .rxeqpole(pole3), .txpreemphasis(pre3),
        .txdiffctrl(diff3), .xaui_status(st3)
    );

    logic        ack_bus;
    logic [31:0] rd_bus;
    assign ack_bus = use3 ? bus3.Sl_xferAck : bus4.Sl_xferAck;
    assign rd_bus  = use3 ? bus3.Sl_DBus    : bus4.Sl_DBus;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr(input int unsigned ch, input int unsigned r);
        return BASE + 32'(ch * 32) + 32'(r * 4);
    endfunction

    task automatic opb_xfer(input logic rnw_i, input logic [31:0] a_i, input logic [31:0] d_i,
                            input logic [0:3] be_i, output logic [31:0] rd_o);
        bit got;
        got  = 1'b0;
        rd_o = '0;
        @(negedge clk);
        abus = a_i; dbus = d_i; be = be_i; rnw = rnw_i; sel = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack_bus) begin
                got  = 1'b1;
                rd_o = rd_bus;
            end
        end
        sel = 1'b0; rnw = 1'b1; be = '0; dbus = '0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("ack_once", 32'(ack_bus), 32'd0);
    endtask

    task automatic wr(input int unsigned ch, input int unsigned r, input logic [31:0] d,
                      input logic [0:3] be_i);
        logic [31:0] dummy;
        opb_xfer(1'b0, addr(ch, r), d, be_i, dummy);
    endtask

    task automatic rd_check(input string tag, input int unsigned ch, input int unsigned r,
                            input logic [31:0] exp);
        logic [31:0] v;
        opb_xfer(1'b1, addr(ch, r), 32'h0, 4'b1111, v);
        check(tag, v, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_txdiff", 32'(diff4), 32'h924);
        check("rst_rxeqmix", 32'(mix4), 32'h0);
        check("rst_rxeqpole", 32'(pole4), 32'h0);
        check("rst_txpre", 32'(pre4), 32'h0);
        check("rst_ack", 32'(bus4.Sl_xferAck), 32'h0);
        check("rst_dbus", bus4.Sl_DBus, 32'h0);
        rd_check("rst_rd_ch2_txdiff", 2, 3, 32'h4);

        wr(1, 1, 32'h0000_000B, 4'b0001);
        check("pole_write", 32'(pole4), 32'h00B0);
        rd_check("pole_rd", 1, 1, 32'hB);
        wr(1, 1, 32'h0000_0005, 4'b1110);
        check("pole_be_gated", 32'(pole4), 32'h00B0);
        rd_check("pole_rd_be_gated", 1, 1, 32'hB);
        wr(0, 3, 32'h3, 4'b0001);
        check("txdiff_ch0", 32'(diff4), 32'h923);
        wr(2, 0, 32'h3, 4'b0001);
        check("mix_ch2", 32'(mix4), 32'h30);
        wr(3, 2, 32'h7, 4'b0001);
        check("pre_ch3", 32'(pre4), 32'hE00);
        rd_check("rsvd_rd", 3, 7, 32'h0);

        @(negedge clk); st4[3] = 1'b1;
        @(negedge clk); st4[3] = 1'b0;
        repeat (3) @(negedge clk);
        rd_check("sticky_set", 0, 5, 32'h08);
        rd_check("status_live_lo", 0, 4, 32'h00);
        wr(0, 5, 32'h08, 4'b0001);
        rd_check("sticky_w1c", 0, 5, 32'h00);
        @(negedge clk); st4[3] = 1'b1;
        repeat (4) @(negedge clk);
        wr(0, 5, 32'h08, 4'b0001);
        rd_check("sticky_set_wins", 0, 5, 32'h08);
        rd_check("status_live_hi", 0, 4, 32'h08);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk); st4[31] = 1'b1;
            repeat (2) @(negedge clk);
            st4[31] = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        rd_check("linkdn_5", 3, 6, 32'd5);

        @(negedge clk);
        force dut4.g_ch[3].u_ch.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut4.g_ch[3].u_ch.cnt_q;
        st4[31] = 1'b1;
        repeat (3) @(negedge clk);
        st4[31] = 1'b0;
        repeat (4) @(negedge clk);
        rd_check("linkdn_sat", 3, 6, 32'hFFFF);

        @(negedge clk); st4[31] = 1'b1;
        repeat (4) @(negedge clk);
        st4[31] = 1'b0;
        @(negedge clk);
        wr(3, 6, 32'h0, 4'b0000);
        rd_check("linkdn_clr_edge", 3, 6, 32'd1);

        use3 = 1'b1;
        wr(3, 3, 32'h1, 4'b0001);
        wr(3, 0, 32'h3, 4'b0001);
        check("oor_txdiff", 32'(diff3), 32'h124);
        check("oor_mix", 32'(mix3), 32'h0);
        rd_check("oor_rd", 3, 3, 32'h0);
        rd_check("oor_valid_rd", 2, 3, 32'h4);
        use3 = 1'b0;

        st4 = '0;
        repeat (4) @(negedge clk);
        abus = addr(1, 0); dbus = 32'h2; be = 4'b0001; rnw = 1'b0; sel = 1'b1;
        @(posedge clk);
        #1;
        check("midack_ack_hi", 32'(bus4.Sl_xferAck), 32'h1);
        check("midack_mix_pre", 32'(mix4), 32'h38);
        #2;
        rst_n = 1'b0;
        #1;
        check("midack_ack_lo", 32'(bus4.Sl_xferAck), 32'h0);
        check("midack_mix", 32'(mix4), 32'h0);
        check("midack_txdiff", 32'(diff4), 32'h924);
        check("midack_txpre", 32'(pre4), 32'h0);
        check("midack_pole", 32'(pole4), 32'h0);
        sel = 1'b0; rnw = 1'b1; be = '0; dbus = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("midack_sticky", 0, 5, 32'h0);
        rd_check("midack_linkdn", 3, 6, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
